// File: rtl/cpu_control_fsm_pkg.sv
// Shared encodings for the multi-cycle control sequencer and the ALU-op decoder.
// States, opcode/ext fields, PC source and writeback mux selects.
package cpu_control_fsm_pkg;

   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM_RD = 3'd4,
      S_MEM_WR = 3'd5,
      S_LINK   = 3'd6,
      S_HALT   = 3'd7
   } state_t;

   localparam logic [3:0] OP_RTYPE   = 4'b0000;
   localparam logic [3:0] OP_SPECIAL = 4'b0100;
   localparam logic [3:0] OP_BCOND   = 4'b1100;
   localparam logic [3:0] OP_CMP     = 4'b1011;

   localparam logic [3:0] EXT_LOAD  = 4'b0000;
   localparam logic [3:0] EXT_STOR  = 4'b0100;
   localparam logic [3:0] EXT_JCOND = 4'b1100;
   localparam logic [3:0] EXT_JAL   = 4'b1000;
   localparam logic [3:0] EXT_CMP   = 4'b1011;

   localparam logic [1:0] PC_SRC_INC   = 2'b00;
   localparam logic [1:0] PC_SRC_DISP  = 2'b01;
   localparam logic [1:0] PC_SRC_REG   = 2'b10;
   localparam logic [1:0] PC_SRC_RESET = 2'b11;

   localparam logic [1:0] WB_SEL_ALU  = 2'b00;
   localparam logic [1:0] WB_SEL_MEM  = 2'b01;
   localparam logic [1:0] WB_SEL_LINK = 2'b10;

   // PC value the datapath loads when pc_src selects PC_SRC_RESET
   localparam logic [15:0] RESET_PC = 16'h0000;

   function automatic logic is_cmp(input logic [3:0] op,
                                   input logic [3:0] ext);
      return (op == OP_CMP) || ((op == OP_RTYPE) && (ext == EXT_CMP));
   endfunction

endpackage

// File: rtl/cpu_control_fsm_timeout.sv
// Bus-master wait counter: counts request cycles without ack and
// flags expiry on the cycle the count would reach LIMIT.
module mem_timeout_counter #(
   parameter int LIMIT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);

   localparam int W = $clog2(LIMIT + 1);

   logic [W-1:0] r_cnt;

   assign o_expired = i_en && (r_cnt == W'(LIMIT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer: fetch over ready/ack port, latch IR,
// and issue per-state commit strobes to the 16-bit datapath.
module cpu_control_fsm
   import cpu_control_fsm_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] mem_data_in,
   input  logic        mem_ack,
   input  logic        cond_met,
   output logic [15:0] ir,
   output logic        ir_load,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_addr_sel,
   output logic        pc_en,
   output logic [1:0]  pc_src,
   output logic        reg_write,
   output logic [1:0]  wb_sel,
   output logic        flags_write,
   output logic        bus_error,
   output logic [2:0]  state_dbg
);

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_ir;
   logic        r_bus_err;

   logic [3:0]  w_op;
   logic [3:0]  w_ext;
   logic        w_special;
   logic        w_is_load;
   logic        w_is_stor;
   logic        w_is_jcond;
   logic        w_is_jal;
   logic        w_is_bcond;
   logic        w_is_cmp;

   logic        w_in_mem;
   logic        w_next_mem;
   logic        w_enter_mem;
   logic        w_tmo_en;
   logic        w_tmo_clr;
   logic        w_expired;

   assign w_op       = r_ir[15:12];
   assign w_ext      = r_ir[7:4];
   assign w_special  = (w_op == OP_SPECIAL);
   assign w_is_load  = w_special && (w_ext == EXT_LOAD);
   assign w_is_stor  = w_special && (w_ext == EXT_STOR);
   assign w_is_jcond = w_special && (w_ext == EXT_JCOND);
   assign w_is_jal   = w_special && (w_ext == EXT_JAL);
   assign w_is_bcond = (w_op == OP_BCOND);
   assign w_is_cmp   = is_cmp(w_op, w_ext);

   // mem_req is a pure function of state, so async reset drops it at once
   assign w_in_mem = (r_state == S_FETCH)
                  || (r_state == S_MEM_RD)
                  || (r_state == S_MEM_WR);

   assign w_next_mem = (w_next == S_FETCH)
                    || (w_next == S_MEM_RD)
                    || (w_next == S_MEM_WR);

   assign w_enter_mem = w_next_mem && (w_next != r_state);
   assign w_tmo_en    = w_in_mem && !mem_ack;
   assign w_tmo_clr   = w_enter_mem || (w_in_mem && mem_ack);

   mem_timeout_counter #(
      .LIMIT     (MEM_TIMEOUT)
   ) u_tmo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clr     (w_tmo_clr),
      .i_en      (w_tmo_en),
      .o_expired (w_expired)
   );

   assign mem_req   = w_in_mem;
   assign ir        = r_ir;
   assign bus_error = r_bus_err;
   assign state_dbg = r_state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_RESET;
         r_ir      <= '0;
         r_bus_err <= 1'b0;
      end else begin
         r_state <= w_next;
         if (ir_load) begin
            r_ir <= mem_data_in;
         end
         if (w_expired) begin
            r_bus_err <= 1'b1;
         end
      end
   end

   always_comb begin
      w_next       = r_state;
      ir_load      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      pc_en        = 1'b0;
      pc_src       = PC_SRC_INC;
      reg_write    = 1'b0;
      wb_sel       = WB_SEL_ALU;
      flags_write  = 1'b0;

      case (r_state)
         S_RESET: begin
            pc_en  = rst_n;
            pc_src = PC_SRC_RESET;
            w_next = S_FETCH;
         end

         S_FETCH: begin
            if (mem_ack) begin
               ir_load = 1'b1;
               w_next  = S_DECODE;
            end else if (w_expired) begin
               w_next = S_HALT;
            end
         end

         S_DECODE: begin
            w_next = S_EXEC;
         end

         S_EXEC: begin
            unique case (1'b1)
               w_is_load: begin
                  w_next = S_MEM_RD;
               end
               w_is_stor: begin
                  w_next = S_MEM_WR;
               end
               w_is_jcond: begin
                  pc_en  = 1'b1;
                  pc_src = cond_met ? PC_SRC_REG : PC_SRC_INC;
                  w_next = S_FETCH;
               end
               w_is_jal: begin
                  w_next = S_LINK;
               end
               w_is_bcond: begin
                  pc_en  = 1'b1;
                  pc_src = cond_met ? PC_SRC_DISP : PC_SRC_INC;
                  w_next = S_FETCH;
               end
               w_is_cmp: begin
                  flags_write = 1'b1;
                  pc_en       = 1'b1;
                  w_next      = S_FETCH;
               end
               default: begin
                  reg_write   = 1'b1;
                  flags_write = 1'b1;
                  pc_en       = 1'b1;
                  w_next      = S_FETCH;
               end
            endcase
         end

         S_MEM_RD: begin
            mem_addr_sel = 1'b1;
            if (mem_ack) begin
               reg_write = 1'b1;
               wb_sel    = WB_SEL_MEM;
               pc_en     = 1'b1;
               w_next    = S_FETCH;
            end else if (w_expired) begin
               w_next = S_HALT;
            end
         end

         S_MEM_WR: begin
            mem_we       = 1'b1;
            mem_addr_sel = 1'b1;
            if (mem_ack) begin
               pc_en  = 1'b1;
               w_next = S_FETCH;
            end else if (w_expired) begin
               w_next = S_HALT;
            end
         end

         // regfile latches old PC+1 while PC takes the pre-write Raddr value
         S_LINK: begin
            reg_write = 1'b1;
            wb_sel    = WB_SEL_LINK;
            pc_en     = 1'b1;
            pc_src    = PC_SRC_REG;
            w_next    = S_FETCH;
         end

         S_HALT: begin
            w_next = S_HALT;
         end
      endcase
   end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: instruction classes, memory waits,
// timeout boundary, halt and asynchronous reset.
module tb_cpu_control_fsm;

   logic        clk;
   logic        rst_n;
   logic [15:0] mem_data_in;
   logic        mem_ack;
   logic        cond_met;
   logic [15:0] ir;
   logic        ir_load;
   logic        mem_req;
   logic        mem_we;
   logic        mem_addr_sel;
   logic        pc_en;
   logic [1:0]  pc_src;
   logic        reg_write;
   logic [1:0]  wb_sel;
   logic        flags_write;
   logic        bus_error;
   logic [2:0]  state_dbg;

   int checks = 0;
   int errors = 0;

   localparam logic [2:0] ST_RESET  = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_MEMRD  = 3'd4;
   localparam logic [2:0] ST_MEMWR  = 3'd5;
   localparam logic [2:0] ST_LINK   = 3'd6;
   localparam logic [2:0] ST_HALT   = 3'd7;

   cpu_control_fsm #(.MEM_TIMEOUT(15)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .mem_data_in  (mem_data_in),
      .mem_ack      (mem_ack),
      .cond_met     (cond_met),
      .ir           (ir),
      .ir_load      (ir_load),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr_sel (mem_addr_sel),
      .pc_en        (pc_en),
      .pc_src       (pc_src),
      .reg_write    (reg_write),
      .wb_sel       (wb_sel),
      .flags_write  (flags_write),
      .bus_error    (bus_error),
      .state_dbg    (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe bundle packed for compact compares:
   // {ir_load,mem_req,mem_we,addr_sel,pc_en,pc_src,reg_write,wb_sel,flags_write}
   function automatic logic [10:0] strobes();
      return {ir_load, mem_req, mem_we, mem_addr_sel, pc_en, pc_src,
              reg_write, wb_sel, flags_write};
   endfunction

   task automatic next_cyc();
      @(negedge clk);
      #1;
   endtask

   // Presents instr after nwait idle cycles; returns one cycle after the ack
   task automatic fetch(input logic [15:0] instr, input int nwait);
      repeat (nwait) next_cyc();
      mem_ack     = 1'b1;
      mem_data_in = instr;
      next_cyc();
      mem_ack     = 1'b0;
      mem_data_in = 16'hDEAD;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      mem_ack = 1'b0;
      mem_data_in = 16'h0000;
      cond_met = 1'b0;
      repeat (2) next_cyc();
      checks++;
      if (state_dbg !== ST_RESET || strobes() !== 11'b0_0_0_0_0_11_0_00_0
          || ir !== 16'h0 || bus_error !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: state=%0d strobes=%b ir=%h err=%b req state=0 strobes=00000110000 ir=0 err=0",
                  state_dbg, strobes(), ir, bus_error);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (state_dbg !== ST_RESET || pc_en !== 1'b1 || pc_src !== 2'b11
          || mem_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_pc: state=%0d pc_en=%b pc_src=%b req=%b want 0 1 11 0",
                  state_dbg, pc_en, pc_src, mem_req);
      end
      next_cyc();
      checks++;
      if (state_dbg !== ST_FETCH || mem_req !== 1'b1 || mem_addr_sel !== 1'b0
          || pc_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_to_fetch: state=%0d req=%b sel=%b pc_en=%b want 1 1 0 0",
                  state_dbg, mem_req, mem_addr_sel, pc_en);
      end
   endtask

   task automatic test_add();
      next_cyc();
      mem_ack     = 1'b1;
      mem_data_in = 16'h0152;
      #1;
      checks++;
      if (ir_load !== 1'b1 || mem_req !== 1'b1 || state_dbg !== ST_FETCH) begin
         errors++;
         $display("FAIL add_irload: ir_load=%b req=%b state=%0d want 1 1 1",
                  ir_load, mem_req, state_dbg);
      end
      next_cyc();
      mem_ack = 1'b0;
      mem_data_in = 16'hDEAD;
      checks++;
      if (state_dbg !== ST_DECODE || ir !== 16'h0152 || strobes() !== 11'b0) begin
         errors++;
         $display("FAIL add_decode: state=%0d ir=%h strobes=%b want 2 0152 0",
                  state_dbg, ir, strobes());
      end
      next_cyc();
      checks++;
      if (state_dbg !== ST_EXEC || strobes() !== 11'b0_0_0_0_1_00_1_00_1) begin
         errors++;
         $display("FAIL add_exec: state=%0d strobes=%b want 3 00001001001",
                  state_dbg, strobes());
      end
      next_cyc();
      checks++;
      if (state_dbg !== ST_FETCH || ir !== 16'h0152) begin
         errors++;
         $display("FAIL add_back: state=%0d ir=%h want 1 0152", state_dbg, ir);
      end
   endtask

   task automatic test_load();
      fetch(16'h4304, 0);
      next_cyc();
      checks++;
      if (state_dbg !== ST_EXEC || strobes() !== 11'b0) begin
         errors++;
         $display("FAIL load_exec: state=%0d strobes=%b want 3 0", state_dbg, strobes());
      end
      next_cyc();
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (state_dbg !== ST_MEMRD || strobes() !== 11'b0_1_0_1_0_00_0_00_0) begin
            errors++;
            $display("FAIL load_wait%0d: state=%0d strobes=%b want 4 01010000000",
                     i, state_dbg, strobes());
         end
         next_cyc();
      end
      mem_ack = 1'b1;
      #1;
      checks++;
      if (state_dbg !== ST_MEMRD || strobes() !== 11'b0_1_0_1_1_00_1_01_0) begin
         errors++;
         $display("FAIL load_ack: state=%0d strobes=%b want 4 01011001010",
                  state_dbg, strobes());
      end
      next_cyc();
      mem_ack = 1'b0;
      checks++;
      if (state_dbg !== ST_FETCH || bus_error !== 1'b0) begin
         errors++;
         $display("FAIL load_back: state=%0d err=%b want 1 0", state_dbg, bus_error);
      end
   endtask

   task automatic test_store();
      checks++;
      if (mem_we !== 1'b0) begin
         errors++;
         $display("FAIL stor_fetch_we: mem_we=%b want 0", mem_we);
      end
      fetch(16'h4344, 0);
      next_cyc();
      checks++;
      if (state_dbg !== ST_EXEC || reg_write !== 1'b0 || mem_we !== 1'b0) begin
         errors++;
         $display("FAIL stor_exec: state=%0d rw=%b we=%b want 3 0 0",
                  state_dbg, reg_write, mem_we);
      end
      next_cyc();
      mem_ack = 1'b1;
      #1;
      checks++;
      if (state_dbg !== ST_MEMWR || strobes() !== 11'b0_1_1_1_1_00_0_00_0) begin
         errors++;
         $display("FAIL stor_ack: state=%0d strobes=%b want 5 01111000000",
                  state_dbg, strobes());
      end
      next_cyc();
      mem_ack = 1'b0;
      checks++;
      if (state_dbg !== ST_FETCH || mem_we !== 1'b0 || reg_write !== 1'b0) begin
         errors++;
         $display("FAIL stor_back: state=%0d we=%b rw=%b want 1 0 0",
                  state_dbg, mem_we, reg_write);
      end
   endtask

   task automatic test_bcond();
      logic [1:0] exp_src [2];
      exp_src[0] = 2'b01;
      exp_src[1] = 2'b00;
      for (int k = 0; k < 2; k++) begin
         cond_met = (k == 0);
         fetch(16'hC005, 0);
         next_cyc();
         checks++;
         if (state_dbg !== ST_EXEC || pc_en !== 1'b1 || pc_src !== exp_src[k]
             || reg_write !== 1'b0 || flags_write !== 1'b0) begin
            errors++;
            $display("FAIL bcond_c%0d: state=%0d pc_en=%b src=%b rw=%b fw=%b want 3 1 %b 0 0",
                     1 - k, state_dbg, pc_en, pc_src, reg_write, flags_write, exp_src[k]);
         end
         next_cyc();
      end
      cond_met = 1'b0;
   endtask

   task automatic test_jcond();
      cond_met = 1'b1;
      fetch(16'h41C3, 0);
      next_cyc();
      checks++;
      if (state_dbg !== ST_EXEC || pc_en !== 1'b1 || pc_src !== 2'b10
          || reg_write !== 1'b0) begin
         errors++;
         $display("FAIL jcond: state=%0d pc_en=%b src=%b rw=%b want 3 1 10 0",
                  state_dbg, pc_en, pc_src, reg_write);
      end
      cond_met = 1'b0;
      #1;
      checks++;
      if (pc_src !== 2'b00 || pc_en !== 1'b1) begin
         errors++;
         $display("FAIL jcond_nc: src=%b pc_en=%b want 00 1", pc_src, pc_en);
      end
      next_cyc();
   endtask

   task automatic test_jal();
      fetch(16'h4586, 0);
      next_cyc();
      checks++;
      if (state_dbg !== ST_EXEC || strobes() !== 11'b0) begin
         errors++;
         $display("FAIL jal_exec: state=%0d strobes=%b want 3 0", state_dbg, strobes());
      end
      next_cyc();
      checks++;
      if (state_dbg !== ST_LINK || strobes() !== 11'b0_0_0_0_1_10_1_10_0) begin
         errors++;
         $display("FAIL jal_link: state=%0d strobes=%b want 6 00001101100",
                  state_dbg, strobes());
      end
      next_cyc();
      checks++;
      if (state_dbg !== ST_FETCH) begin
         errors++;
         $display("FAIL jal_back: state=%0d want 1", state_dbg);
      end
   endtask

   task automatic test_cmp();
      logic [15:0] ops [2];
      ops[0] = 16'hB012;
      ops[1] = 16'h01B2;
      for (int k = 0; k < 2; k++) begin
         fetch(ops[k], 0);
         mem_ack = 1'b1;
         next_cyc();
         checks++;
         if (state_dbg !== ST_EXEC || strobes() !== 11'b0_0_0_0_1_00_0_00_1) begin
            errors++;
            $display("FAIL cmp_%h: state=%0d strobes=%b want 3 00001000001",
                     ops[k], state_dbg, strobes());
         end
         mem_ack = 1'b0;
         next_cyc();
      end
   endtask

   task automatic test_timeout_edge();
      fetch(16'h0152, 14);
      checks++;
      if (state_dbg !== ST_DECODE || bus_error !== 1'b0 || ir !== 16'h0152) begin
         errors++;
         $display("FAIL tmo_edge: state=%0d err=%b ir=%h want 2 0 0152",
                  state_dbg, bus_error, ir);
      end
      repeat (2) next_cyc();
   endtask

   task automatic test_timeout_halt();
      for (int i = 0; i < 15; i++) begin
         checks++;
         if (state_dbg !== ST_FETCH || mem_req !== 1'b1 || bus_error !== 1'b0) begin
            errors++;
            $display("FAIL tmo_wait%0d: state=%0d req=%b err=%b want 1 1 0",
                     i, state_dbg, mem_req, bus_error);
         end
         next_cyc();
      end
      checks++;
      if (state_dbg !== ST_HALT || bus_error !== 1'b1 || strobes() !== 11'b0) begin
         errors++;
         $display("FAIL tmo_halt: state=%0d err=%b strobes=%b want 7 1 0",
                  state_dbg, bus_error, strobes());
      end
      mem_ack     = 1'b1;
      mem_data_in = 16'h4304;
      repeat (3) next_cyc();
      checks++;
      if (state_dbg !== ST_HALT || ir !== 16'h0152 || ir_load !== 1'b0
          || bus_error !== 1'b1) begin
         errors++;
         $display("FAIL halt_ack: state=%0d ir=%h ld=%b err=%b want 7 0152 0 1",
                  state_dbg, ir, ir_load, bus_error);
      end
      #2;
      rst_n   = 1'b0;
      mem_ack = 1'b0;
      #1;
      checks++;
      if (state_dbg !== ST_RESET || strobes() !== 11'b0_0_0_0_0_11_0_00_0
          || ir !== 16'h0 || bus_error !== 1'b0) begin
         errors++;
         $display("FAIL async_rst: state=%0d strobes=%b ir=%h err=%b want 0 00000110000 0 0",
                  state_dbg, strobes(), ir, bus_error);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (state_dbg !== ST_RESET || pc_en !== 1'b1 || pc_src !== 2'b11) begin
         errors++;
         $display("FAIL rst_release: state=%0d pc_en=%b src=%b want 0 1 11",
                  state_dbg, pc_en, pc_src);
      end
      next_cyc();
      checks++;
      if (state_dbg !== ST_FETCH || mem_req !== 1'b1 || bus_error !== 1'b0) begin
         errors++;
         $display("FAIL rst_refetch: state=%0d req=%b err=%b want 1 1 0",
                  state_dbg, mem_req, bus_error);
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_load();
      test_store();
      test_bcond();
      test_jcond();
      test_jal();
      test_cmp();
      test_timeout_edge();
      test_timeout_halt();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
